snax_csr_channel_router: RTL and testbench

SNAX_CSR_CHANNEL_ROUTER -- requirements
Module: snax_csr_channel_router

---
 rtl/snax_csr_channel_router.sv | 158 +++++++++++++++
 tb/tb_snax_csr_channel_router.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snax_csr_channel_router.sv
// Routes upstream CSR requests to per-accelerator CSR channels and returns read responses in issue order.
// Define SNAX_CSR_ROUTER_ERR_CNT_EN to add err_count_o, a saturating count of accepted out-of-range requests.
module snax_csr_channel_router #(
  parameter int          NumChannels    = 2,
  parameter logic [31:0] CsrBase        = 32'h3C0,
  parameter int          CsrPerChannel  = 16,
  parameter int          MaxOutstanding = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [31:0]              req_addr_i,
  input  logic [31:0]              req_data_i,
  input  logic                     req_write_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_data_o,
  output logic                     rsp_err_o,
  output logic [NumChannels-1:0]   csr_req_valid_o,
  input  logic [NumChannels-1:0]   csr_req_ready_i,
  output logic [31:0]              csr_req_addr_o,
  output logic [31:0]              csr_req_data_o,
  output logic                     csr_req_write_o,
  input  logic [NumChannels-1:0]   csr_rsp_valid_i,
  output logic [NumChannels-1:0]   csr_rsp_ready_o,
  input  logic [NumChannels*32-1:0] csr_rsp_data_i,
  output logic                     barrier_o
`ifdef SNAX_CSR_ROUTER_ERR_CNT_EN
  ,
  output logic [15:0]              err_count_o
`endif
);

  localparam int OffW = $clog2(CsrPerChannel);
  localparam int TagW = $clog2(NumChannels + 1);
  localparam int PtrW = $clog2(MaxOutstanding);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  // Tag value one past the last channel marks an out-of-range read.
  localparam logic [TagW-1:0] TagErr = TagW'(NumChannels);

  logic [31:0]     off;
  logic [31:0]     chan_sel;
  logic            in_range;
  logic            fifo_full;
  logic            fifo_empty;
  logic            rd_ok;
  logic            sel_ready;
  logic            push;
  logic            pop;
  logic [TagW-1:0] tag_in;
  logic [TagW-1:0] head_tag;
  logic            head_err;
  logic            head_vld;
  logic [31:0]     head_data;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TagW-1:0] tag_mem_q [MaxOutstanding];
  logic [TagW-1:0] tag_mem_d [MaxOutstanding];

  assign off            = req_addr_i - CsrBase;
  assign chan_sel       = off >> OffW;
  assign in_range       = (req_addr_i >= CsrBase) && (chan_sel < 32'(NumChannels));
  assign csr_req_addr_o = off & 32'(CsrPerChannel - 1);
  assign csr_req_data_o  = req_data_i;
  assign csr_req_write_o = req_write_i;

  assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);
  // Reads need a free tracking slot; writes never produce a response.
  assign rd_ok      = req_write_i | ~fifo_full;

  always_comb begin
    sel_ready       = 1'b0;
    csr_req_valid_o = '0;
    for (int c = 0; c < NumChannels; c++) begin
      if (chan_sel == 32'(c)) begin
        sel_ready          = csr_req_ready_i[c];
        csr_req_valid_o[c] = req_valid_i & in_range & rd_ok;
      end
    end
  end

  assign req_ready_o = in_range ? (sel_ready & rd_ok) : rd_ok;

  assign head_tag = tag_mem_q[rd_ptr_q];
  assign head_err = (head_tag == TagErr);

  always_comb begin
    head_vld        = 1'b0;
    head_data       = '0;
    csr_rsp_ready_o = '0;
    for (int c = 0; c < NumChannels; c++) begin
      if (head_tag == TagW'(c)) begin
        head_vld           = csr_rsp_valid_i[c];
        head_data          = csr_rsp_data_i[32*c +: 32];
        csr_rsp_ready_o[c] = rsp_ready_i & ~fifo_empty;
      end
    end
  end

  assign rsp_valid_o = ~fifo_empty & (head_err | head_vld);
  assign rsp_data_o  = (fifo_empty | head_err) ? 32'h0 : head_data;
  assign rsp_err_o   = ~fifo_empty & head_err;
  assign barrier_o   = fifo_empty & ~req_valid_i;

  assign push   = req_valid_i & req_ready_o & ~req_write_i;
  assign pop    = rsp_valid_o & rsp_ready_i;
  assign tag_in = in_range ? TagW'(chan_sel) : TagErr;

  always_comb begin
    tag_mem_d = tag_mem_q;
    if (push) tag_mem_d[wr_ptr_q] = tag_in;
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Tag storage carries data only; occupancy decides which entries are live.
  always_ff @(posedge clk_i) begin
    tag_mem_q <= tag_mem_d;
  end

`ifdef SNAX_CSR_ROUTER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign err_cnt_d   = (req_valid_i & req_ready_o & ~in_range) ? sat_inc(err_cnt_q) : err_cnt_q;
  assign err_count_o = err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end
`endif

endmodule

// File: tb/tb_snax_csr_channel_router.sv
// Bench for snax_csr_channel_router: directed scenarios with literal expectations, then random traffic
// against a queue-based reference model with behavioural downstream devices.
module tb_snax_csr_channel_router;
  localparam int          NCH  = 2;
  localparam logic [31:0] BASE = 32'h3C0;
  localparam int          CPC  = 16;
  localparam int          MAXO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [NCH-1:0] csr_req_valid, csr_req_ready, csr_rsp_valid, csr_rsp_ready;
  logic [31:0] csr_req_addr, csr_req_data;
  logic        csr_req_write;
  logic [NCH*32-1:0] csr_rsp_data;
  logic        barrier;
`ifdef SNAX_CSR_ROUTER_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  always #5 clk = ~clk;

  snax_csr_channel_router #(
    .NumChannels(NCH), .CsrBase(BASE), .CsrPerChannel(CPC), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_write_i(req_write),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .csr_req_valid_o(csr_req_valid), .csr_req_ready_i(csr_req_ready), .csr_req_addr_o(csr_req_addr),
    .csr_req_data_o(csr_req_data), .csr_req_write_o(csr_req_write),
    .csr_rsp_valid_i(csr_rsp_valid), .csr_rsp_ready_o(csr_rsp_ready), .csr_rsp_data_i(csr_rsp_data),
    .barrier_o(barrier)
`ifdef SNAX_CSR_ROUTER_ERR_CNT_EN
    , .err_count_o(err_count)
`endif
  );

  // Reference state: outstanding read tags (-1 = error), device queues, expected response order.
  int          tagq[$];
  logic [31:0] dev0[$];
  logic [31:0] dev1[$];
  logic [32:0] exp_rsp[$];
  int          err_cnt;
  bit          chk_en, rand_mode;
  int          n_chk, n_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0]    off;
    int             idx, head;
    bit             in_rng, ok, empty, e_ready, e_rvalid;
    logic [NCH-1:0] e_cvalid, e_crready;
    logic [31:0]    e_rdata, d;
    off    = req_addr - BASE;
    idx    = int'(off / CPC);
    in_rng = (req_addr >= BASE) && (off / CPC < NCH);
    ok     = req_write || (tagq.size() < MAXO);
    e_ready = ok;
    if (in_rng) e_ready = csr_req_ready[idx] && ok;
    e_cvalid = '0;
    if (req_valid && in_rng && ok) e_cvalid[idx] = 1'b1;
    empty     = (tagq.size() == 0);
    head      = empty ? -2 : tagq[0];
    e_rvalid  = !empty && (head < 0 || csr_rsp_valid[head]);
    e_rdata   = (empty || head < 0) ? 32'h0 : csr_rsp_data[32*head +: 32];
    e_crready = '0;
    if (rsp_ready && !empty && head >= 0) e_crready[head] = 1'b1;
    if (chk_en) begin
      chk("req_ready", req_ready, e_ready);
      chk("csr_req_valid", csr_req_valid, e_cvalid);
      chk("csr_req_addr", csr_req_addr, off % CPC);
      chk("csr_req_data", {csr_req_write, csr_req_data}, {req_write, req_data});
      chk("rsp_valid", rsp_valid, e_rvalid);
      chk("rsp_data", {rsp_err, rsp_data}, {(!empty && head < 0), e_rdata});
      chk("csr_rsp_ready", csr_rsp_ready, e_crready);
      chk("barrier", barrier, empty && !req_valid);
`ifdef SNAX_CSR_ROUTER_ERR_CNT_EN
      chk("err_count", err_count, err_cnt);
`endif
    end
    if (rst) begin
      tagq.delete(); dev0.delete(); dev1.delete(); exp_rsp.delete(); err_cnt = 0;
      return;
    end
    if (e_rvalid && rsp_ready) begin
      if (rand_mode) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          chk("rsp_order", {rsp_err, rsp_data}, exp_rsp[0]);
          void'(exp_rsp.pop_front());
        end
        if (head == 0) void'(dev0.pop_front());
        if (head == 1) void'(dev1.pop_front());
      end
      void'(tagq.pop_front());
    end
    if (req_valid && e_ready) begin
      if (!in_rng && err_cnt < 65535) err_cnt++;
      if (!req_write) begin
        tagq.push_back(in_rng ? idx : -1);
        if (rand_mode) begin
          d = $urandom;
          if (!in_rng) exp_rsp.push_back({1'b1, 32'h0});
          else begin
            exp_rsp.push_back({1'b0, d});
            if (idx == 0) dev0.push_back(d); else dev1.push_back(d);
          end
        end
      end
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic advance();
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic v, input logic [31:0] a, input logic w, input logic [31:0] dt);
    req_valid = v; req_addr = a; req_write = w; req_data = dt;
  endtask

  task automatic drive_random();
    rst = ($urandom_range(0, 599) == 0);
    req_valid = ($urandom % 10) < 7;
    req_write = ($urandom % 10) < 4;
    req_data  = $urandom;
    case ($urandom % 8)
      0, 1, 2: req_addr = BASE + ($urandom % 16);
      3, 4, 5: req_addr = BASE + 16 + ($urandom % 16);
      6:       req_addr = BASE + 32 + ($urandom % 64);
      default: req_addr = ($urandom % 2) ? ($urandom % BASE) : $urandom;
    endcase
    rsp_ready        = ($urandom % 4) != 0;
    csr_req_ready[0] = ($urandom % 4) != 0;
    csr_req_ready[1] = ($urandom % 4) != 0;
    csr_rsp_valid[0] = (dev0.size() > 0) && (($urandom % 3) != 0);
    csr_rsp_valid[1] = (dev1.size() > 0) && (($urandom % 3) != 0);
    csr_rsp_data[31:0]  = csr_rsp_valid[0] ? dev0[0] : $urandom;
    csr_rsp_data[63:32] = csr_rsp_valid[1] ? dev1[0] : $urandom;
  endtask

  initial begin
    n_chk = 0; n_err = 0; err_cnt = 0; chk_en = 0; rand_mode = 0;
    rst = 1'b1; rsp_ready = 1'b1; csr_req_ready = '0; csr_rsp_valid = '0; csr_rsp_data = '0;
    drive_req(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    settle(); advance();
    chk_en = 1;

    // Reset state
    settle();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_csr_rsp_ready", csr_rsp_ready, 2'b00);
    chk("rst_barrier", barrier, 1);
    chk("rst_req_ready", req_ready, 1);
    advance();

    // Write to channel 0 offset 5
    rst = 1'b0; csr_req_ready = 2'b01;
    drive_req(1'b1, 32'h3C5, 1'b1, 32'hAB);
    settle();
    chk("wr_valid", csr_req_valid, 2'b01);
    chk("wr_addr", csr_req_addr, 5);
    chk("wr_data", csr_req_data, 32'hAB);
    chk("wr_ready", req_ready, 1);
    chk("wr_no_rsp", rsp_valid, 0);
    advance();
    drive_req(1'b0, 32'h0, 1'b0, 32'h0);
    settle();
    chk("wr_barrier", barrier, 1);
    advance();

    // Reads ch1 then ch0; ch0 answers first but must wait
    csr_req_ready = 2'b11;
    drive_req(1'b1, 32'h3D2, 1'b0, 32'h0);
    settle();
    chk("rd1_valid", csr_req_valid, 2'b10);
    chk("rd1_addr", csr_req_addr, 2);
    advance();
    drive_req(1'b1, 32'h3C1, 1'b0, 32'h0);
    settle();
    chk("rd0_valid", csr_req_valid, 2'b01);
    chk("rd0_addr", csr_req_addr, 1);
    advance();
    drive_req(1'b0, 32'h0, 1'b0, 32'h0);
    csr_rsp_valid = 2'b01; csr_rsp_data = {32'h0, 32'h11};
    settle();
    chk("ord_hold_valid", rsp_valid, 0);
    chk("ord_hold_ready", csr_rsp_ready, 2'b10);
    advance();
    csr_rsp_valid = 2'b11; csr_rsp_data = {32'h22, 32'h11};
    settle();
    chk("ord_first", {rsp_valid, rsp_err, rsp_data}, {2'b10, 32'h22});
    chk("ord_first_ready", csr_rsp_ready, 2'b10);
    advance();
    csr_rsp_valid = 2'b01;
    settle();
    chk("ord_second", {rsp_valid, rsp_err, rsp_data}, {2'b10, 32'h11});
    chk("ord_second_ready", csr_rsp_ready, 2'b01);
    advance();
    csr_rsp_valid = 2'b00;

    // Out-of-range read
    rsp_ready = 1'b0;
    drive_req(1'b1, 32'h3E0, 1'b0, 32'h0);
    settle();
    chk("oor_ready", req_ready, 1);
    chk("oor_no_fwd", csr_req_valid, 2'b00);
    advance();
    drive_req(1'b0, 32'h0, 1'b0, 32'h0);
    rsp_ready = 1'b1;
    settle();
    chk("oor_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b11, 32'h0});
`ifdef SNAX_CSR_ROUTER_ERR_CNT_EN
    chk("oor_err_count", err_count, 1);
`endif
    advance();

    // Fill the tracker with reads to a stalled ch0
    csr_req_ready = 2'b01;
    for (int i = 0; i < MAXO; i++) begin
      drive_req(1'b1, 32'h3C3, 1'b0, 32'h0);
      settle();
      chk("fill_ready", req_ready, 1);
      advance();
    end
    csr_req_ready = 2'b10;
    drive_req(1'b1, 32'h3D4, 1'b1, 32'h5);
    settle();
    chk("full_wr_ready", req_ready, 1);
    chk("full_wr_valid", csr_req_valid, 2'b10);
    advance();
    csr_req_ready = 2'b01; csr_rsp_valid = 2'b01; csr_rsp_data = {32'h0, 32'h55};
    drive_req(1'b1, 32'h3C3, 1'b0, 32'h0);
    settle();
    chk("full_rd_ready", req_ready, 0);
    chk("full_rd_valid", csr_req_valid, 2'b00);
    chk("full_pop", rsp_valid, 1);
    advance();

    // Reset with three tags outstanding
    csr_rsp_valid = 2'b00;
    drive_req(1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    settle(); advance();
    rst = 1'b0; csr_rsp_valid = 2'b11;
    settle();
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_csr_rsp_ready", csr_rsp_ready, 2'b00);
    chk("post_rst_barrier", barrier, 1);
    advance();

    // Random traffic
    rand_mode = 1; rst = 1'b1; csr_rsp_valid = 2'b00;
    settle(); advance();
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
